// File: rtl/snake_pkg.sv
// Shared encodings for the snake body engine and its segment store.
package snake_pkg;

    // Movement direction as delivered by the direction/tick controller.
    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    // Segment type as seen by the renderer.
    typedef enum logic [1:0] {
        SEG_BODY = 2'b00,
        SEG_HEAD = 2'b01,
        SEG_TAIL = 2'b10,
        SEG_NONE = 2'b11
    } seg_type_e;

    // Engine control states.
    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StCalc,
        StScan,
        StCommit,
        StDone,
        StDead
    } state_e;

    localparam int unsigned SegTypeW = 2;

    // Up/down and left/right differ only in bit 0.
    function automatic dir_e dir_opposite(input dir_e d);
        return dir_e'({d[1], ~d[0]});
    endfunction

endpackage

// File: rtl/snake_seg_store.sv
// Physical segment register file: one write port with head/tail retype side
// channels, a combinational scan port and a registered render port.
module snake_seg_store
    import snake_pkg::*;
#(
    parameter int unsigned X_W     = 8,
    parameter int unsigned Y_W     = 7,
    parameter int unsigned MAX_LEN = 64,
    localparam int unsigned AW     = $clog2(MAX_LEN),
    localparam int unsigned SEG_W  = SegTypeW + X_W + Y_W
) (
    input  logic             clk,
    input  logic             reset_n,
    // Full-segment write
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [SEG_W-1:0] wdata,
    // Type-only rewrites used when a new head is committed
    input  logic             body_we,
    input  logic [AW-1:0]    body_addr,
    input  logic             tail_we,
    input  logic [AW-1:0]    tail_addr,
    // Collision scan port
    input  logic [AW-1:0]    scan_addr,
    output logic [X_W-1:0]   scan_x,
    output logic [Y_W-1:0]   scan_y,
    // Renderer port
    input  logic [AW-1:0]    rd_addr,
    output logic [SEG_W-1:0] rd_data
);

    logic [SEG_W-1:0] mem [MAX_LEN];
    logic [SEG_W-1:0] rd_q;

    // Storage update; a tail retype wins over a body retype on the same entry
    // (length-2 snake whose old head becomes the new tail).
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (body_we) begin
            mem[body_addr][SEG_W-1 -: SegTypeW] <= SEG_BODY;
        end
        if (tail_we) begin
            mem[tail_addr][SEG_W-1 -: SegTypeW] <= SEG_TAIL;
        end
    end

    // Render read samples the array before any same-edge write lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[rd_addr];
        end
    end

    assign scan_x  = mem[scan_addr][Y_W +: X_W];
    assign scan_y  = mem[scan_addr][Y_W-1:0];
    assign rd_data = rd_q;

endmodule

// File: rtl/snake_body_engine.sv
// Snake body manager: circular segment buffer with growth, edge wrap,
// reversal rejection and serial self-collision scan.
module snake_body_engine
    import snake_pkg::*;
#(
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned MAX_LEN  = 64,
    parameter int unsigned INIT_LEN = 6,
    parameter int unsigned INIT_X   = 20,
    parameter int unsigned INIT_Y   = 10,
    parameter int unsigned X_MAX    = 159,
    parameter int unsigned Y_MAX    = 119,
    localparam int unsigned AW      = $clog2(MAX_LEN),
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             restart,
    input  logic             step_valid,
    output logic             step_ready,
    input  logic [1:0]       dir,
    input  logic             grow,
    output logic             done,
    output logic             collide,
    output logic             dead,
    output logic [LEN_W-1:0] length,
    output logic [X_W-1:0]   head_x,
    output logic [Y_W-1:0]   head_y,
    input  logic [AW-1:0]    rd_idx,
    output logic [X_W-1:0]   rd_x,
    output logic [Y_W-1:0]   rd_y,
    output logic [1:0]       rd_type
);

    typedef struct packed {
        seg_type_e      kind;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } seg_t;

    localparam logic [X_W-1:0]   XMax     = X_W'(X_MAX);
    localparam logic [Y_W-1:0]   YMax     = Y_W'(Y_MAX);
    localparam logic [X_W-1:0]   XInit    = X_W'(INIT_X);
    localparam logic [Y_W-1:0]   YInit    = Y_W'(INIT_Y);
    localparam logic [LEN_W-1:0] LenInit  = LEN_W'(INIT_LEN);
    localparam logic [LEN_W-1:0] LenMax   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] InitLast = LEN_W'(INIT_LEN - 1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    head_ptr_q, head_ptr_d;
    logic [LEN_W-1:0] length_q, length_d;
    dir_e             last_dir_q, last_dir_d;
    logic             collide_q, collide_d;
    logic [X_W-1:0]   head_x_q, head_x_d;
    logic [Y_W-1:0]   head_y_q, head_y_d;
    dir_e             dir_q, dir_d;
    logic             grow_q, grow_d;
    logic [X_W-1:0]   new_x_q, new_x_d;
    logic [Y_W-1:0]   new_y_q, new_y_d;
    dir_e             eff_dir_q, eff_dir_d;
    logic             grow_eff_q, grow_eff_d;
    logic [LEN_W-1:0] scan_n_q, scan_n_d;
    logic             rd_invalid_q;

    dir_e             eff_dir;
    logic [X_W-1:0]   calc_x;
    logic [Y_W-1:0]   calc_y;
    logic             grow_eff;
    seg_t             init_seg;

    logic             we;
    logic [AW-1:0]    waddr;
    seg_t             wdata;
    logic             body_we;
    logic             tail_we;
    logic [AW-1:0]    tail_addr;
    logic [AW-1:0]    scan_addr;
    logic [X_W-1:0]   scan_x;
    logic [Y_W-1:0]   scan_y;
    logic             scan_hit;
    seg_t             rd_seg;

    // Candidate head: reversal falls back to the previous direction, edges wrap.
    always_comb begin
        eff_dir = dir_q;
        if (dir_q == dir_opposite(last_dir_q)) begin
            eff_dir = last_dir_q;
        end
        calc_x = head_x_q;
        calc_y = head_y_q;
        unique case (eff_dir)
            DIR_UP:    calc_y = (head_y_q == '0)   ? YMax : head_y_q - 1'b1;
            DIR_DOWN:  calc_y = (head_y_q == YMax) ? '0   : head_y_q + 1'b1;
            DIR_LEFT:  calc_x = (head_x_q == '0)   ? XMax : head_x_q - 1'b1;
            DIR_RIGHT: calc_x = (head_x_q == XMax) ? '0   : head_x_q + 1'b1;
            default:   calc_x = head_x_q;
        endcase
        grow_eff = grow_q && (length_q < LenMax);
    end

    // Segment laid down by the init sequence at logical index cnt_q.
    always_comb begin
        init_seg.x = XInit;
        init_seg.y = YInit + Y_W'(cnt_q);
        if (cnt_q == '0) begin
            init_seg.kind = SEG_HEAD;
        end else if (cnt_q == InitLast) begin
            init_seg.kind = SEG_TAIL;
        end else begin
            init_seg.kind = SEG_BODY;
        end
    end

    assign scan_addr = head_ptr_q + AW'(cnt_q);
    assign scan_hit  = (scan_x == new_x_q) && (scan_y == new_y_q);
    // New tail sits at old logical index length-2 once the head pointer steps back.
    assign tail_addr = head_ptr_q + AW'(length_q) - AW'(2);

    // Next-state, store write controls and the done pulse.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        head_ptr_d = head_ptr_q;
        length_d   = length_q;
        last_dir_d = last_dir_q;
        collide_d  = collide_q;
        head_x_d   = head_x_q;
        head_y_d   = head_y_q;
        dir_d      = dir_q;
        grow_d     = grow_q;
        new_x_d    = new_x_q;
        new_y_d    = new_y_q;
        eff_dir_d  = eff_dir_q;
        grow_eff_d = grow_eff_q;
        scan_n_d   = scan_n_q;
        we         = 1'b0;
        waddr      = head_ptr_q + AW'(cnt_q);
        wdata      = init_seg;
        body_we    = 1'b0;
        tail_we    = 1'b0;
        done       = 1'b0;

        if (restart) begin
            // Abandon anything in flight: no write, no done.
            state_d   = StInit;
            cnt_d     = '0;
            collide_d = 1'b0;
            length_d  = '0;
        end else begin
            unique case (state_q)
                StInit: begin
                    we = 1'b1;
                    if (cnt_q == '0) begin
                        head_x_d = XInit;
                        head_y_d = YInit;
                    end
                    if (cnt_q == InitLast) begin
                        state_d    = StIdle;
                        cnt_d      = '0;
                        length_d   = LenInit;
                        collide_d  = 1'b0;
                        last_dir_d = DIR_UP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StIdle: begin
                    if (step_valid) begin
                        dir_d   = dir_e'(dir);
                        grow_d  = grow;
                        state_d = StCalc;
                    end
                end
                StCalc: begin
                    new_x_d    = calc_x;
                    new_y_d    = calc_y;
                    eff_dir_d  = eff_dir;
                    grow_eff_d = grow_eff;
                    // Without growth the tail moves out, so it cannot be hit.
                    scan_n_d   = grow_eff ? length_q : length_q - 1'b1;
                    cnt_d      = '0;
                    state_d    = StScan;
                end
                StScan: begin
                    if (scan_hit) begin
                        collide_d = 1'b1;
                        done      = 1'b1;
                        state_d   = StDead;
                    end else if (cnt_q == scan_n_q - 1'b1) begin
                        cnt_d   = '0;
                        state_d = StCommit;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StCommit: begin
                    we         = 1'b1;
                    waddr      = head_ptr_q - 1'b1;
                    wdata      = '{kind: SEG_HEAD, x: new_x_q, y: new_y_q};
                    body_we    = 1'b1;
                    tail_we    = !grow_eff_q;
                    head_ptr_d = head_ptr_q - 1'b1;
                    length_d   = length_q + LEN_W'(grow_eff_q);
                    last_dir_d = eff_dir_q;
                    head_x_d   = new_x_q;
                    head_y_d   = new_y_q;
                    state_d    = StDone;
                end
                StDone: begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
                StDead: begin
                    state_d = StDead;
                end
                default: begin
                    state_d = StInit;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StInit;
            cnt_q      <= '0;
            head_ptr_q <= '0;
            length_q   <= '0;
            last_dir_q <= DIR_UP;
            collide_q  <= 1'b0;
            head_x_q   <= '0;
            head_y_q   <= '0;
            dir_q      <= DIR_UP;
            grow_q     <= 1'b0;
            new_x_q    <= '0;
            new_y_q    <= '0;
            eff_dir_q  <= DIR_UP;
            grow_eff_q <= 1'b0;
            scan_n_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            head_ptr_q <= head_ptr_d;
            length_q   <= length_d;
            last_dir_q <= last_dir_d;
            collide_q  <= collide_d;
            head_x_q   <= head_x_d;
            head_y_q   <= head_y_d;
            dir_q      <= dir_d;
            grow_q     <= grow_d;
            new_x_q    <= new_x_d;
            new_y_q    <= new_y_d;
            eff_dir_q  <= eff_dir_d;
            grow_eff_q <= grow_eff_d;
            scan_n_q   <= scan_n_d;
        end
    end

    // Out-of-range flag, registered alongside the render read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_invalid_q <= 1'b1;
        end else begin
            rd_invalid_q <= (LEN_W'(rd_idx) >= length_q);
        end
    end

    snake_seg_store #(
        .X_W     (X_W),
        .Y_W     (Y_W),
        .MAX_LEN (MAX_LEN)
    ) u_store (
        .clk       (clk),
        .reset_n   (reset_n),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .body_we   (body_we),
        .body_addr (head_ptr_q),
        .tail_we   (tail_we),
        .tail_addr (tail_addr),
        .scan_addr (scan_addr),
        .scan_x    (scan_x),
        .scan_y    (scan_y),
        .rd_addr   (head_ptr_q + rd_idx),
        .rd_data   (rd_seg)
    );

    assign step_ready = (state_q == StIdle);
    assign dead       = (state_q == StDead);
    assign collide    = collide_q;
    assign length     = length_q;
    assign head_x     = head_x_q;
    assign head_y     = head_y_q;
    assign rd_x       = rd_invalid_q ? '0 : rd_seg.x;
    assign rd_y       = rd_invalid_q ? '0 : rd_seg.y;
    assign rd_type    = rd_invalid_q ? SEG_NONE : rd_seg.kind;

endmodule
